uart_tx_fifo: RTL

Second-generation UART transmitter with a built-in transmit FIFO.
- Runtime-programmable baud divisor, data length (5-8 bits), optional even/odd parity and 1 or 2 stop bits.
- Sits between the CPU memory-mapped I/O register and the TX pin.
- CPU pushes bytes through a ready/valid handshake and does not poll per byte.
- Frames are sent back-to-back, with no idle gap, while the FIFO is non-empty.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 46 ++++
 rtl/uart_tx_fifo.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, framing constants and helpers for the UART family
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

    localparam logic [1:0] LEN_5 = 2'd0;
    localparam logic [1:0] LEN_6 = 2'd1;
    localparam logic [1:0] LEN_7 = 2'd2;
    localparam logic [1:0] LEN_8 = 2'd3;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DIV_1MBAUD = 50;

    // index of the final data bit for a given length code (5 bits -> 4 ... 8 bits -> 7)
    function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
        return 3'(len) + 3'd4;
    endfunction

    // keeps only the data bits that belong to the frame, so parity ignores unused MSBs
    function automatic logic [7:0] len_mask(input logic [1:0] len);
        return 8'hFF >> (2'd3 - len);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock registered FIFO with full/empty flags and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rd_data = mem[rd_ptr];

    // storage array; writes while full are dropped
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with programmable framing, fed back-to-back from a TX FIFO
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                 i_Clock,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] i_Div,
    input  logic [1:0]           i_Data_Len,
    input  logic                 i_Parity_En,
    input  logic                 i_Parity_Odd,
    input  logic                 i_Two_Stop,
    input  logic                 i_Tx_DV,
    input  logic [7:0]           i_Tx_Byte,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Done,
    output logic [CNT_WIDTH-1:0] o_Fifo_Count,
    output logic                 o_Overflow
);
    uart_state_t          state, state_n;
    logic [DIV_WIDTH-1:0] cnt, cnt_n, div_q;
    logic [2:0]           bit_idx, bit_n;
    logic [7:0]           shreg, fifo_data;
    logic [1:0]           len_q;
    logic                 par_en_q, par_odd_q, two_stop_q;
    logic                 serial_n, full, empty, pop, bit_end, stop_last, parity;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (i_Clock),
        .rst    (reset),
        .wr_en  (i_Tx_DV),
        .wr_data(i_Tx_Byte),
        .rd_en  (pop),
        .rd_data(fifo_data),
        .full   (full),
        .empty  (empty),
        .count  (o_Fifo_Count)
    );

    assign o_Tx_Ready  = !full;
    assign o_Tx_Active = state != IDLE;
    assign bit_end     = cnt == div_q - 1'b1;
    assign stop_last   = bit_end && (!two_stop_q || bit_idx[0]);
    assign parity      = ^shreg ^ par_odd_q;
    assign pop         = !empty && (state == IDLE || (state == STOP && stop_last));

    // next state, bit timing and the line level the serial register will take
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        case (state)
            IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (!empty) state_n = START;
            end
            START: if (bit_end) begin
                cnt_n   = '0;
                state_n = DATA;
            end
            DATA: if (bit_end) begin
                cnt_n = '0;
                bit_n = bit_idx + 3'd1;
                if (bit_idx == last_bit_idx(len_q)) begin
                    bit_n   = '0;
                    state_n = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: if (bit_end) begin
                cnt_n   = '0;
                state_n = STOP;
            end
            STOP: if (bit_end) begin
                cnt_n   = '0;
                bit_n   = stop_last ? 3'd0 : 3'd1;
                state_n = !stop_last ? STOP : empty ? IDLE : START;
            end
            default: begin
                cnt_n   = '0;
                bit_n   = '0;
                state_n = IDLE;
            end
        endcase
        serial_n = state_n == START  ? 1'b0 :
                   state_n == DATA   ? shreg[bit_n] :
                   state_n == PARITY ? parity : 1'b1;
    end

    // frame sequencer, registered line, done pulse and sticky overflow
    always_ff @(posedge i_Clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Done   <= 1'b0;
            o_Overflow  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_n;
            o_Tx_Serial <= serial_n;
            o_Tx_Done   <= state == STOP && stop_last;
            if (i_Tx_DV && full) o_Overflow <= 1'b1;
        end
    end

    // byte and framing are captured at pop so mid-frame changes only hit the next frame
    always_ff @(posedge i_Clock) begin
        if (pop) begin
            shreg      <= fifo_data & len_mask(i_Data_Len);
            div_q      <= (i_Div[DIV_WIDTH-1:1] == '0) ? DIV_WIDTH'(2) : i_Div;
            len_q      <= i_Data_Len;
            par_en_q   <= i_Parity_En;
            par_odd_q  <= i_Parity_Odd;
            two_stop_q <= i_Two_Stop;
        end
    end

endmodule
